// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame controller: FSM state
// encoding, TX output mux select codes and the default payload width.
package uart_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_DATA  = 2'b01;
    localparam logic [1:0] SEL_PAR   = 2'b10;
    localparam logic [1:0] SEL_STOP  = 2'b11;

    // Mux select driven while the FSM sits in a given state; idle shares the
    // stop code so the line rests at the stop level.
    function automatic logic [1:0] sel_for_state(input logic [2:0] st);
        logic [1:0] sel;
        case (st)
            ST_START:  sel = SEL_START;
            ST_DATA:   sel = SEL_DATA;
            ST_PARITY: sel = SEL_PAR;
            default:   sel = SEL_STOP;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity of a payload word: even parity is the XOR of all
// bits, odd parity its inverse.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (^p_data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller / serializer. One bit per clock; all
// outputs are registered alongside the state register.
// Build option: define UART_TX_PARITY_EN to compile in the parity bit,
// the PARITY state and the PAR_EN/PAR_TYP capture. Without it the frame is
// always start + DATA_WIDTH data bits + stop and PAR_BIT stays 0.
//
// state     | meaning
// ----------|------------------------------------------------------------
// ST_IDLE   | line idle, Busy low, waiting for DATA_VALID
// ST_START  | start bit on the line
// ST_DATA   | payload bits, LSB first, one per cycle
// ST_PARITY | parity bit (only reachable with parity compiled in)
// ST_STOP   | stop bit; DATA_VALID here chains the next frame
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            MUX_SEL,
    output logic                  Busy,
    output logic                  SER_DATA,
    output logic                  PAR_BIT
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            mux_sel_q, mux_sel_d;
    logic                  busy_q, busy_d;
    logic                  ser_data_q, ser_data_d;
    logic                  par_bit_q, par_bit_d;

    logic accept;
    logic par_en_lat;
    logic par_calc;

    assign accept = DATA_VALID && ((state_q == ST_IDLE) || (state_q == ST_STOP));

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .p_data  (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_calc)
    );

    // Parity enable is frozen for the whole frame at acceptance.
    always_comb begin
        par_en_d = accept ? PAR_EN : par_en_q;
    end

    // Parity enable register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_en_q <= 1'b0;
        end else begin
            par_en_q <= par_en_d;
        end
    end

    assign par_en_lat = par_en_q;
`else
    logic unused_par_inputs;

    assign unused_par_inputs = PAR_EN ^ PAR_TYP;
    assign par_calc          = 1'b0;
    assign par_en_lat        = 1'b0;
`endif

    // Next state, shifter and counter; outputs are derived from the next
    // state so they change on the same edge as the state register. The data
    // bit is registered as it is shifted out, so SER_DATA during DATA cycle c
    // carries payload bit c.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        ser_data_d = 1'b0;
        par_bit_d  = par_bit_q;

        case (state_q)
            ST_IDLE, ST_STOP: begin
                if (accept) begin
                    state_d   = ST_START;
                    shift_d   = P_DATA;
                    par_bit_d = par_calc;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d    = ST_DATA;
                cnt_d      = '0;
                ser_data_d = shift_q[0];
                shift_d    = shift_q >> 1;
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = par_en_lat ? ST_PARITY : ST_STOP;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    ser_data_d = shift_q[0];
                    shift_d    = shift_q >> 1;
                end
            end
            ST_PARITY: begin
                state_d = ST_STOP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d    = (state_d != ST_IDLE);
        mux_sel_d = sel_for_state(state_d);
    end

    // State, datapath and output registers; reset abandons any frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            mux_sel_q  <= SEL_STOP;
            busy_q     <= 1'b0;
            ser_data_q <= 1'b0;
            par_bit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            mux_sel_q  <= mux_sel_d;
            busy_q     <= busy_d;
            ser_data_q <= ser_data_d;
            par_bit_q  <= par_bit_d;
        end
    end

    assign MUX_SEL  = mux_sel_q;
    assign Busy     = busy_q;
    assign SER_DATA = ser_data_q;
    assign PAR_BIT  = par_bit_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl. Honours UART_TX_PARITY_EN the same
// way the design does.
module tb_uart_tx_ctrl;

    localparam int W = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] P_DATA;
    logic         DATA_VALID;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic [1:0]   MUX_SEL;
    logic         Busy;
    logic         SER_DATA;
    logic         PAR_BIT;

    uart_tx_ctrl #(
        .DATA_WIDTH (W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .MUX_SEL    (MUX_SEL),
        .Busy       (Busy),
        .SER_DATA   (SER_DATA),
        .PAR_BIT    (PAR_BIT)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Length of the most recent uninterrupted Busy run.
    int busy_run = 0;
    int last_run = 0;

    always @(negedge CLK) begin
        if (RST) begin
            busy_run = 0;
        end else if (Busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
    end

    typedef struct {
        logic       busy;
        logic [1:0] mux;
        logic       ser;
        logic       chk_ser;
    } cyc_t;

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] data2;
        logic         pen;
        logic         ptyp;
        logic         chain;
        logic         noise;
        int           exp_len;
        logic         exp_par;
    } vec_t;

    cyc_t exp_q[$];
    vec_t vecs[7];
    logic exp_par_now;
    logic held_par;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_parity(input logic [W-1:0] d, input logic ptyp);
        int ones = 0;
        for (int i = 0; i < W; i++) begin
            if (d[i]) ones++;
        end
        if (!PAR_BUILD) return 1'b0;
        return ((ones % 2) == 1) ^ ptyp;
    endfunction

    // Expected per-cycle view of one frame, starting with the cycle right
    // after the accepting edge and ending with the stop cycle.
    task automatic build_frame(input logic [W-1:0] d, input logic pen);
        exp_q.delete();
        exp_q.push_back('{1'b1, 2'b00, 1'b0, 1'b0});
        for (int i = 0; i < W; i++) begin
            exp_q.push_back('{1'b1, 2'b01, d[i], 1'b1});
        end
        if (pen && PAR_BUILD) exp_q.push_back('{1'b1, 2'b10, 1'b0, 1'b0});
        exp_q.push_back('{1'b1, 2'b11, 1'b0, 1'b0});
    endtask

    // Called #1 after an edge while idle or in a stop cycle; returns #1
    // after the edge that produced this frame's stop cycle. Inputs are
    // scrambled every cycle after acceptance; with noise set DATA_VALID is
    // also pulsed randomly mid-frame.
    task automatic send_frame(input logic [W-1:0] d, input logic pen, input logic ptyp,
                              input logic noise);
        build_frame(d, pen);
        exp_par_now = model_parity(d, ptyp);
        P_DATA      = d;
        PAR_EN      = pen;
        PAR_TYP     = ptyp;
        DATA_VALID  = 1'b1;
        @(posedge CLK);
        #1;
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("busy[%0d]", k), 32'(Busy), 32'(exp_q[k].busy));
            chk($sformatf("mux_sel[%0d]", k), 32'(MUX_SEL), 32'(exp_q[k].mux));
            if (exp_q[k].chk_ser) chk($sformatf("ser_data[%0d]", k), 32'(SER_DATA), 32'(exp_q[k].ser));
            chk($sformatf("par_bit[%0d]", k), 32'(PAR_BIT), 32'(exp_par_now));
            P_DATA  = W'($urandom);
            PAR_EN  = 1'($urandom);
            PAR_TYP = 1'($urandom);
            if (k == exp_q.size() - 1) begin
                DATA_VALID = 1'b0;
            end else begin
                DATA_VALID = noise ? 1'($urandom) : 1'b0;
                @(posedge CLK);
                #1;
            end
        end
        held_par = exp_par_now;
    endtask

    task automatic idle_step();
        DATA_VALID = 1'b0;
        @(posedge CLK);
        #1;
        chk("idle_busy", 32'(Busy), 32'd0);
        chk("idle_mux", 32'(MUX_SEL), 32'd3);
        chk("idle_par_hold", 32'(PAR_BIT), 32'(held_par));
    endtask

    // From a stop cycle: drop to idle, then check the total Busy run length.
    task automatic finish_frame(input int exp_len);
        idle_step();
        @(negedge CLK);
        #1;
        chk("busy_len", 32'(last_run), 32'(exp_len));
        @(posedge CLK);
        #1;
        chk("idle_busy2", 32'(Busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   nf;
        int   len;
        logic [W-1:0] rd;
        logic rp, rt, rn;

        //           data    data2   pen   ptyp  chain noise len par (parity build)
        vecs[0] = '{8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b0};
        vecs[1] = '{8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 11, 1'b0};
        vecs[2] = '{8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 11, 1'b1};
        vecs[3] = '{8'h01, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 20, 1'b1};
        vecs[4] = '{8'h3C, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 11, 1'b0};
        vecs[5] = '{8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 11, 1'b1};
        vecs[6] = '{8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 10, 1'b0};

        RST        = 1'b1;
        DATA_VALID = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        held_par   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_mux", 32'(MUX_SEL), 32'd3);
        chk("rst_ser", 32'(SER_DATA), 32'd0);
        chk("rst_par", 32'(PAR_BIT), 32'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("post_rst_busy", 32'(Busy), 32'd0);

        for (int t = 0; t < 7; t++) begin
            v = vecs[t];
            send_frame(v.data, v.pen, v.ptyp, v.noise);
            if (v.chain) send_frame(v.data2, v.pen, v.ptyp, v.noise);
            chk($sformatf("tbl_par[%0d]", t), 32'(PAR_BIT), PAR_BUILD ? 32'(v.exp_par) : 32'd0);
            finish_frame(PAR_BUILD ? v.exp_len : (v.chain ? 2 * (W + 2) : W + 2));
        end

        // Reset asserted during the 4th data bit abandons the frame.
        P_DATA     = 8'h5A;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b1;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1;
        DATA_VALID = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("mid_mux", 32'(MUX_SEL), 32'd1);
        chk("mid_ser_bit3", 32'(SER_DATA), 32'd1);
        RST = 1'b1;
        #1;
        chk("async_rst_busy", 32'(Busy), 32'd0);
        @(posedge CLK);
        #1;
        chk("rst_mid_busy", 32'(Busy), 32'd0);
        chk("rst_mid_mux", 32'(MUX_SEL), 32'd3);
        chk("rst_mid_ser", 32'(SER_DATA), 32'd0);
        chk("rst_mid_par", 32'(PAR_BIT), 32'd0);
        RST      = 1'b0;
        held_par = 1'b0;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        finish_frame(PAR_BUILD ? 11 : 10);

        // Random frames, random chaining and idle gaps.
        for (int r = 0; r < 40; r++) begin
            nf  = $urandom_range(1, 3);
            len = 0;
            for (int f = 0; f < nf; f++) begin
                rd = W'($urandom);
                rp = 1'($urandom);
                rt = 1'($urandom);
                rn = 1'($urandom);
                send_frame(rd, rp, rt, rn);
                len += W + 2 + ((rp && PAR_BUILD) ? 1 : 0);
            end
            finish_frame(len);
            repeat ($urandom_range(0, 2)) idle_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame controller and serializer for the UART transmitter, directly upstream of the TX output mux stage. Accepts a parallel byte with a valid strobe, sequences start/data/parity/stop phases one bit per clock (clock is the bit-rate clock), and drives the mux select, busy flag, serial data bit and parity bit. The output stage registers these once more before the line, so the line lags this block by one cycle.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame (≥ 2).
- `CLK` input 1: bit-rate clock, rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `P_DATA` input DATA_WIDTH: parallel payload, sampled only on acceptance.
- `DATA_VALID` input 1: payload request strobe.
- `PAR_EN` input 1: 1 = insert parity bit, sampled on acceptance.
- `PAR_TYP` input 1: 0 = even, 1 = odd; sampled on acceptance.
- `MUX_SEL` output 2: 00 start, 01 data, 10 parity, 11 stop/idle.
- `Busy` output 1: high for every cycle of a frame.
- `SER_DATA` output 1: current payload bit, LSB first.
- `PAR_BIT` output 1: parity of the accepted payload.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance: `DATA_VALID`=1 in IDLE, or in the STOP cycle (back-to-back). On acceptance: latch `P_DATA` into shift register, latch `PAR_EN`, compute and latch `PAR_BIT` (even: XOR of bits; odd: its inverse); next state START.
- `DATA_VALID` in START/DATA/PARITY: ignored, no queuing; `P_DATA` changes mid-frame have no effect.
- START → DATA. DATA: bit counter 0..DATA_WIDTH-1, shift right each cycle; at count DATA_WIDTH-1 → PARITY if latched `PAR_EN`, else STOP. PARITY → STOP. STOP → START on acceptance, else IDLE.
- Counter width $clog2(DATA_WIDTH); cleared on entering DATA; no wrap is ever observed.
- All outputs are registered, updated together with the state register.
- Outputs per state: IDLE `Busy`=0, `MUX_SEL`=11; START 1/00; DATA 1/01, `SER_DATA`=shift[0]; PARITY 1/10; STOP 1/11. `PAR_BIT` holds its latched value until next acceptance.

## Timing
- Reset (any time, including mid-frame): state IDLE, `Busy`=0, `MUX_SEL`=11, `SER_DATA`=0, `PAR_BIT`=0, counter 0, shift register 0. Frame in progress is abandoned.
- `DATA_VALID` high at edge n in IDLE: START at n+1, data bits n+2..n+1+DATA_WIDTH, parity (if enabled) next, then STOP one cycle.
- Frame length: DATA_WIDTH+2 cycles, +1 with parity (10/11 for default).
- Back-to-back: `DATA_VALID` in STOP cycle gives START the very next cycle, `Busy` never drops.
- Minimum idle gap otherwise: one IDLE cycle.

## Configuration
- `UART_TX_PARITY_EN` defined: parity logic, PARITY state and `PAR_EN`/`PAR_TYP` latching compiled in as above.
- Not defined: `PAR_EN`/`PAR_TYP` ignored, PARITY state unreachable, `PAR_BIT` constant 0, frame always DATA_WIDTH+2 cycles.

## Structure
- Package `uart_tx_pkg`: state encoding, `MUX_SEL` constants (SEL_START, SEL_DATA, SEL_PAR, SEL_STOP), default DATA_WIDTH.
- Sub-module `uart_parity_calc`: combinational parity from payload and `PAR_TYP`, instantiated under the macro.

## Test plan
- Reset mid-DATA (RST pulsed at 4th data bit) → next cycle `Busy`=0, `MUX_SEL`=11, state IDLE; new frame accepted normally afterwards.
- `P_DATA`=8'hA5, PAR_EN=0 → `MUX_SEL` 00, 01×8, 11; `SER_DATA` 1,0,1,0,0,1,0,1; `Busy` high exactly 10 cycles.
- `P_DATA`=8'hA5, PAR_EN=1, PAR_TYP=0 → parity cycle `MUX_SEL`=10, `PAR_BIT`=0; PAR_TYP=1 → `PAR_BIT`=1; `Busy` 11 cycles.
- `P_DATA`=8'h01 then `DATA_VALID` in STOP with 8'hFF → second START immediately after STOP, `Busy` continuous 20 cycles.
- `DATA_VALID` pulsed and `P_DATA` changed during DATA phase → current frame bits unchanged, no second frame.
- Build without `UART_TX_PARITY_EN`, PAR_EN=1 → no 10 select, 10-cycle frame, `PAR_BIT`=0.
